// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - cpu memory-bus bridge: I/O decode, UART TX/RX FIFOs, cycle counter, halt flag
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-low reset
//   rdy_in                 global ready; low freezes cpu-side state (RX capture and TX drain continue)
//   cpu_a/cpu_dout/cpu_wr  cpu bus request (address bits 17:0 decoded)
//   cpu_din                read data, one cycle after the read address
//   io_buffer_full         tells the cpu to stop I/O writes (registered)
//   ram_we, ram_dout       RAM write enable and RAM read data (1-cycle latency)
//   tx_data/tx_valid/tx_ready  byte stream toward the UART transmitter
//   rx_data/rx_valid       byte strobe from the UART receiver
//   program_halt           sticky halt flag set by a write to 0x30004
module io_bridge #(
    parameter int TX_DEPTH_BIT = 3,
    parameter int RX_DEPTH_BIT = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_halt
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_BIT;
    localparam int RX_DEPTH = 1 << RX_DEPTH_BIT;
    localparam logic [TX_DEPTH_BIT:0] TX_DEPTH_C = TX_DEPTH[TX_DEPTH_BIT:0];
    localparam logic [TX_DEPTH_BIT:0] MARGIN_C   = FULL_MARGIN[TX_DEPTH_BIT:0];
    localparam logic [RX_DEPTH_BIT:0] RX_DEPTH_C = RX_DEPTH[RX_DEPTH_BIT:0];

    // Address decode
    logic io_sel, is_data, is_cnt, is_cnt0;
    logic unused_addr;

    assign io_sel      = (cpu_a[17:16] == 2'b11);
    assign is_data     = io_sel && (cpu_a[15:0] == 16'h0000);
    assign is_cnt      = io_sel && (cpu_a[15:2] == 14'h0001);
    assign is_cnt0     = is_cnt && (cpu_a[1:0] == 2'b00);
    assign unused_addr = &{1'b0, cpu_a[31:18]};

    // Gated by reset so the RAM never sees a write strobe while the bridge is held in reset.
    assign ram_we = cpu_wr & ~io_sel & rst_in;

    // TX FIFO
    logic [7:0]              tx_mem [TX_DEPTH];
    logic [TX_DEPTH_BIT-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_DEPTH_BIT:0]   tx_count, tx_count_next;
    logic                    tx_full, tx_push, tx_pop;
    logic [7:0]              tx_push_data;

    assign tx_full      = (tx_count == TX_DEPTH_C);
    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_mem[tx_rd_ptr];
    // A write to 0x30004 always enqueues a 0x00 marker; a 0x00 written to the data port is not data.
    assign tx_push      = rdy_in & cpu_wr & ((is_data & (cpu_dout != 8'h00)) | is_cnt0) & ~tx_full;
    assign tx_pop       = tx_valid & tx_ready;
    assign tx_push_data = is_data ? cpu_dout : 8'h00;

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + 1'b1;
            2'b01:   tx_count_next = tx_count - 1'b1;
            default: tx_count_next = tx_count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count       <= tx_count_next;
            // Computed from the post-update count so the flag rises the cycle after the push that crosses the margin.
            io_buffer_full <= ((TX_DEPTH_C - tx_count_next) <= MARGIN_C);
        end
    end

    // RX FIFO
    logic [7:0]              rx_mem [RX_DEPTH];
    logic [RX_DEPTH_BIT-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_DEPTH_BIT:0]   rx_count;
    logic                    rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_count == RX_DEPTH_C);
    assign rx_empty = (rx_count == '0);
    // RX capture ignores rdy_in so no UART byte is lost while the cpu is stalled.
    assign rx_push  = rx_valid & ~rx_full;
    // An empty FIFO never pops, so a same-cycle push into an empty FIFO is kept and the read sees 0x00.
    assign rx_pop   = rdy_in & ~cpu_wr & is_data & ~rx_empty;

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Cycle counter and halt
    logic [31:0] cycle_cnt, cnt_snap;
    logic        halt;

    assign program_halt = halt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            halt      <= 1'b0;
        end else if (rdy_in) begin
            if (!halt) cycle_cnt <= cycle_cnt + 32'd1;
            if (cpu_wr && is_cnt0) halt <= 1'b1;
        end
    end

    // Read path: the I/O byte is resolved in the address cycle and held for the data cycle.
    logic [7:0] io_byte, io_rdata;
    logic       ram_q;

    always_comb begin
        io_byte = 8'h00;
        if (!cpu_wr) begin
            if (is_data && !rx_empty) begin
                io_byte = rx_mem[rx_rd_ptr];
            end else if (is_cnt) begin
                case (cpu_a[1:0])
                    // Byte 0 comes from the live counter: it is the value being snapshotted this cycle.
                    2'b00:   io_byte = cycle_cnt[7:0];
                    2'b01:   io_byte = cnt_snap[15:8];
                    2'b10:   io_byte = cnt_snap[23:16];
                    default: io_byte = cnt_snap[31:24];
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ram_q    <= 1'b0;
            io_rdata <= 8'h00;
            cnt_snap <= '0;
        end else if (rdy_in) begin
            ram_q    <= ~io_sel;
            io_rdata <= io_byte;
            if (!cpu_wr && is_cnt0) cnt_snap <= cycle_cnt;
        end
    end

    assign cpu_din = ram_q ? ram_dout : io_rdata;

endmodule
